// File: rtl/zwait_mc.sv
// rtl/zwait_mc.sv - multi-channel Z80 /WAIT generator with per-channel release and timeout
module zwait_mc #(
  parameter int CHANNELS = 2,
  parameter int TMO_W    = 12
) (
  input  logic                fclk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] end_ch,
  input  logic                end_all,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic [TMO_W-1:0]    tmo_limit,
  input  logic                tmo_clr,
  output logic [CHANNELS-1:0] waits,
  output logic [CHANNELS-1:0] tmo_flags,
  output logic [2:0]          cur_ch,
  output wire                 wait_n,
  output logic                spiint_n
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] waits_q, waits_d;
  logic [CHANNELS-1:0] flags_q, flags_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;

  logic                fire;
  logic [CHANNELS-1:0] set_mask;
  logic [CHANNELS-1:0] clr_mask;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      waits_q <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      waits_q <= waits_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear first, then set: a start always survives a simultaneous release or timeout.
  always_comb begin
    fire     = (state_q == S_WAIT) && (tmo_limit != '0) &&
               (cnt_q == tmo_limit - TMO_W'(1));
    set_mask = start & ch_en;
    clr_mask = end_ch | {CHANNELS{end_all}} | ~ch_en | (fire ? waits_q : '0);
    waits_d  = (waits_q & ~clr_mask) | set_mask;
    flags_d  = (tmo_clr ? '0 : flags_q) | (fire ? (waits_q & ~set_mask) : '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE, S_GAP: state_d = (waits_d != '0) ? S_WAIT : S_IDLE;
      S_WAIT:        if (fire || (waits_d == '0)) state_d = S_GAP;
      default:       state_d = S_IDLE;
    endcase
    // A partial release restarts the timeout for the channels still waiting.
    if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
      if ((waits_q & ~waits_d) != '0) cnt_d = '0;
      else if (&cnt_q)                 cnt_d = cnt_q;
      else                             cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_comb begin
    cur_ch = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (waits_q[i]) cur_ch = 3'(i);
    end
  end

  assign waits     = waits_q;
  assign tmo_flags = flags_q;
  assign spiint_n  = ~|waits_q;
  assign wait_n    = (state_q == S_WAIT) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_zwait_mc.sv
// tb/tb_zwait_mc.sv - self-checking bench for zwait_mc
module tb_zwait_mc;
  localparam int C  = 2;
  localparam int TW = 12;

  logic          fclk = 1'b0;
  logic          rst_n = 1'b1;
  logic [C-1:0]  start = '0, end_ch = '0, ch_en = '1;
  logic          end_all = 1'b0, tmo_clr = 1'b0;
  logic [TW-1:0] tmo_limit = '0;
  logic [C-1:0]  waits, tmo_flags;
  logic [2:0]    cur_ch;
  logic          spiint_n;
  wire           wait_line;

  pullup (wait_line);

  zwait_mc #(.CHANNELS(C), .TMO_W(TW)) dut (
    .fclk(fclk), .rst_n(rst_n), .start(start), .end_ch(end_ch), .end_all(end_all),
    .ch_en(ch_en), .tmo_limit(tmo_limit), .tmo_clr(tmo_clr), .waits(waits),
    .tmo_flags(tmo_flags), .cur_ch(cur_ch), .wait_n(wait_line), .spiint_n(spiint_n)
  );

  always #5 fclk = ~fclk;

  int checks = 0;
  int passes = 0;

  // Reference: which channels are pending, whether /WAIT is held, and how long this episode has run.
  logic [C-1:0] m_waits = '0, m_flags = '0;
  bit           m_lo = 1'b0;
  int           m_el = 0;

  typedef struct {
    logic [1:0] st;
    logic [1:0] ec;
    logic       ea;
    logic [1:0] en;
    int         lim;
    logic       clr;
    logic [1:0] ew;
    logic [1:0] ef;
    int         ecur;
    logic       ewt;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_waits = '0; m_flags = '0; m_lo = 1'b0; m_el = 0;
  endtask

  task automatic model_step();
    bit fire;
    logic [C-1:0] nxt, setm;
    fire = m_lo && (tmo_limit != 0) && (m_el == int'(tmo_limit) - 1);
    setm = start & ch_en;
    for (int i = 0; i < C; i++)
      nxt[i] = (m_waits[i] && !(end_ch[i] || end_all || !ch_en[i] || fire)) || setm[i];
    if (tmo_clr) m_flags = '0;
    if (fire) m_flags = m_flags | (m_waits & ~setm);
    if (m_lo) begin
      if (fire || nxt == 0) m_lo = 1'b0;
      else if ((m_waits & ~nxt) != 0) m_el = 0;
      else if (m_el < (1 << TW) - 1) m_el = m_el + 1;
    end else if (nxt != 0) begin
      m_lo = 1'b1;
      m_el = 0;
    end
    m_waits = nxt;
  endtask

  task automatic cmp_model();
    int exp_cur;
    exp_cur = 0;
    for (int i = 0; i < C; i++) begin
      if (m_waits[i]) begin
        exp_cur = i;
        break;
      end
    end
    check("waits", int'(waits), int'(m_waits));
    check("tmo_flags", int'(tmo_flags), int'(m_flags));
    check("cur_ch", int'(cur_ch), exp_cur);
    check("wait_n", int'(wait_line), m_lo ? 0 : 1);
    check("spiint_n", int'(spiint_n), (m_waits == 0) ? 1 : 0);
  endtask

  task automatic clr_strobes();
    start = '0; end_ch = '0; end_all = 1'b0; tmo_clr = 1'b0;
  endtask

  task automatic cyc();
    model_step();
    @(posedge fclk);
    #1;
    cmp_model();
    clr_strobes();
  endtask

  initial begin
    int lows;
    #1 rst_n = 1'b0;
    #2;
    check("rst_waits", int'(waits), 0);
    check("rst_flags", int'(tmo_flags), 0);
    check("rst_cur", int'(cur_ch), 0);
    check("rst_wait_n", int'(wait_line), 1);
    check("rst_spiint", int'(spiint_n), 1);
    @(posedge fclk); @(posedge fclk); #1;
    rst_n = 1'b1;
    model_reset();

    // st, ec, ea, en, lim, clr  ->  waits, flags, cur_ch, wait line
    tbl.push_back('{2'b10, 2'b00, 1'b0, 2'b11, 0, 1'b0, 2'b10, 2'b00, 1, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b11, 0, 1'b0, 2'b10, 2'b00, 1, 1'b0});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 2'b11, 0, 1'b0, 2'b11, 2'b00, 0, 1'b0});
    tbl.push_back('{2'b00, 2'b10, 1'b0, 2'b11, 0, 1'b0, 2'b01, 2'b00, 0, 1'b0});
    tbl.push_back('{2'b01, 2'b00, 1'b1, 2'b11, 0, 1'b0, 2'b01, 2'b00, 0, 1'b0});
    tbl.push_back('{2'b10, 2'b00, 1'b0, 2'b01, 0, 1'b0, 2'b01, 2'b00, 0, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b10, 0, 1'b0, 2'b00, 2'b00, 0, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b11, 0, 1'b0, 2'b00, 2'b00, 0, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 1'b1, 2'b11, 0, 1'b0, 2'b00, 2'b00, 0, 1'b1});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 2'b11, 0, 1'b0, 2'b01, 2'b00, 0, 1'b0});
    tbl.push_back('{2'b00, 2'b01, 1'b0, 2'b11, 0, 1'b0, 2'b00, 2'b00, 0, 1'b1});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 2'b11, 0, 1'b0, 2'b01, 2'b00, 0, 1'b0});
    tbl.push_back('{2'b00, 2'b01, 1'b0, 2'b11, 0, 1'b0, 2'b00, 2'b00, 0, 1'b1});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 2'b11, 3, 1'b0, 2'b01, 2'b00, 0, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b11, 3, 1'b0, 2'b01, 2'b00, 0, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b11, 3, 1'b0, 2'b01, 2'b00, 0, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b11, 3, 1'b0, 2'b00, 2'b01, 0, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b11, 3, 1'b1, 2'b00, 2'b00, 0, 1'b1});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 2'b11, 3, 1'b0, 2'b01, 2'b00, 0, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b11, 3, 1'b0, 2'b01, 2'b00, 0, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b11, 3, 1'b0, 2'b01, 2'b00, 0, 1'b0});
    tbl.push_back('{2'b10, 2'b00, 1'b0, 2'b11, 3, 1'b1, 2'b10, 2'b01, 1, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b11, 3, 1'b0, 2'b10, 2'b01, 1, 1'b0});
    tbl.push_back('{2'b00, 2'b10, 1'b0, 2'b11, 3, 1'b0, 2'b00, 2'b01, 0, 1'b1});

    foreach (tbl[r]) begin
      start = tbl[r].st; end_ch = tbl[r].ec; end_all = tbl[r].ea; ch_en = tbl[r].en;
      tmo_limit = TW'(tbl[r].lim); tmo_clr = tbl[r].clr;
      model_step();
      @(posedge fclk);
      #1;
      check($sformatf("tbl%0d_waits", r), int'(waits), int'(tbl[r].ew));
      check($sformatf("tbl%0d_flags", r), int'(tmo_flags), int'(tbl[r].ef));
      check($sformatf("tbl%0d_cur", r), int'(cur_ch), tbl[r].ecur);
      check($sformatf("tbl%0d_wait_n", r), int'(wait_line), int'(tbl[r].ewt));
      clr_strobes();
    end
    ch_en = '1; tmo_clr = 1'b1; tmo_limit = '0;
    cyc();

    // Plain release: low from the start edge until the release edge, then one GAP.
    start = 2'b01; cyc();
    lows = (wait_line == 1'b0) ? 1 : 0;
    for (int k = 0; k < 9; k++) begin
      cyc();
      if (wait_line == 1'b0) lows++;
    end
    check("plain_low_cycles", lows, 10);
    end_ch = 2'b01; cyc();
    check("plain_released", int'(wait_line), 1);
    cyc();
    check("plain_idle", int'(wait_line), 1);

    // Timeout of L=5 keeps /WAIT low exactly five cycles.
    tmo_limit = TW'(5);
    start = 2'b01; cyc();
    lows = 0;
    for (int k = 0; k < 20 && wait_line == 1'b0; k++) begin
      lows++;
      cyc();
    end
    check("tmo_low_cycles", lows, 5);
    check("tmo_waits", int'(waits), 0);
    check("tmo_flag_set", int'(tmo_flags), 1);
    tmo_clr = 1'b1; cyc();
    check("tmo_flag_clr", int'(tmo_flags), 0);

    // Counter saturates rather than wrapping, so a later limit of 1 never matches.
    tmo_limit = '0;
    start = 2'b01; cyc();
    repeat (4100) cyc();
    tmo_limit = TW'(1);
    repeat (4100) cyc();
    check("sat_still_waiting", int'(waits), 1);
    check("sat_wait_low", int'(wait_line), 0);
    end_ch = 2'b01; cyc();
    tmo_limit = '0; cyc();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) tmo_limit = TW'($urandom_range(0, 7));
      for (int i = 0; i < C; i++) begin
        start[i]  = ($urandom_range(0, 9) == 0);
        end_ch[i] = ($urandom_range(0, 19) == 0);
        ch_en[i]  = ($urandom_range(0, 29) != 0);
      end
      end_all = ($urandom_range(0, 49) == 0);
      tmo_clr = ($urandom_range(0, 19) == 0);
      cyc();
    end

    // Asynchronous reset while waiting with a flag set.
    ch_en = '1; tmo_limit = TW'(2); tmo_clr = 1'b1; end_all = 1'b1; cyc();
    cyc();
    start = 2'b01; cyc();
    cyc(); cyc();
    start = 2'b01; cyc();
    check("pre_rst_flags", int'(tmo_flags), 1);
    check("pre_rst_wait", int'(wait_line), 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_waits", int'(waits), 0);
    check("arst_flags", int'(tmo_flags), 0);
    check("arst_wait_n", int'(wait_line), 1);
    check("arst_spiint", int'(spiint_n), 1);
    check("arst_cur", int'(cur_ch), 0);
    @(posedge fclk); #1;
    rst_n = 1'b1;
    tmo_limit = '0;
    cyc();
    start = 2'b10; cyc();
    check("post_rst_waits", int'(waits), 2);
    check("post_rst_wait", int'(wait_line), 0);
    end_all = 1'b1; cyc();
    cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
